ts_packet_ring_buffer: RTL and testbench
========================================

// Module: ts_packet_ring_buffer
// PURPOSE
//  Parametrised successor to the two-RAM packet reclocker. Captures a byte-wide TS stream into a ring of
//  SLOTS packet slots, aligned on P_SYNC, and hands out complete packets on request. Drops packets on
//  overflow, discards short packets, and reports occupancy, drop and short counts. Sits between the demod
//  input stage and the packet multiplexer. One clock domain only.
// PARAMETERS
//  DATA_W      8    byte width of DATA / DATA_OUT
//  PKT_LEN     188  bytes per packet (204 for RS-appended streams); range 4..255
//  SLOTS       4    packet slots in the ring; power of 2, >= 2
//  CHECK_SYNC  1    1: a P_SYNC byte is valid only if DATA == 8'h47; 0: P_SYNC alone suffices
//  CNT_W       16   width of DROP_COUNT / SHORT_COUNT
// PORTS
//  SYS_CLK             in   1               single clock
//  RST                 in   1               synchronous reset, active high
//  DATA                in   DATA_W          input byte
//  D_VALID             in   1               DATA qualifier, one byte per cycle when high
//  P_SYNC              in   1               marks first byte of a packet (qualified by D_VALID)
//  GIVE_ME_ONE_PACKET  in   1               read request; honoured only while GOT_FULL_PACKET=1
//  GOT_FULL_PACKET     out  1               at least one committed packet available, reader idle
//  DATA_OUT            out  DATA_W          output byte; 0 when DOUT_VALID=0
//  DOUT_VALID          out  1               DATA_OUT carries packet data
//  DOUT_SYNC           out  1               high with first byte of an output packet
//  PKT_COUNT           out  $clog2(SLOTS)+1 committed, unread packets (excludes packet being read)
//  DROP_COUNT          out  CNT_W           packets dropped for lack of a free slot (saturating)
//  SHORT_COUNT         out  CNT_W           packets aborted by early P_SYNC (saturating)
// BEHAVIOUR
//  Reset: all outputs 0; FSMs to W_HUNT / R_IDLE; slot pointers, byte counters, counts 0. RAM not cleared.
//   Reset mid-packet discards the partial write and any read in progress.
//  Storage: one sync RAM, SLOTS*PKT_LEN words; addr = slot_base + offset; slot_base steps by PKT_LEN,
//   wraps to 0 after slot SLOTS-1. 1-cycle read latency.
//  sync_ok = D_VALID & P_SYNC & (!CHECK_SYNC | DATA==8'h47). Cycles with D_VALID=0 are no-ops for writer.
//  Write FSM:
//   W_HUNT: on sync_ok, if PKT_COUNT + reading < SLOTS: write byte at offset 0, wr_cnt=1, -> W_FILL;
//    else DROP_COUNT+1, stay W_HUNT. Non-sync bytes ignored.
//   W_FILL: sync_ok before packet end -> SHORT_COUNT+1, restart same slot at offset 0 (this byte kept).
//    P_SYNC without 0x47 (CHECK_SYNC=1) is written as ordinary data. Byte at wr_cnt==PKT_LEN-1:
//    write it, commit slot (PKT_COUNT+1 next cycle), advance write slot, -> W_HUNT.
//  Read FSM:
//   R_IDLE: GOT_FULL_PACKET registered = (PKT_COUNT>0). Request in cycle T with GOT_FULL_PACKET=1 ->
//    GOT_FULL_PACKET=0 and PKT_COUNT-1 at T+1, reading=1, -> R_READ. Request while 0: ignored.
//   R_READ: byte 0 on DATA_OUT with DOUT_VALID=DOUT_SYNC=1 at T+2; bytes 1..PKT_LEN-1 on consecutive
//    cycles, no gaps. Cycle after the last byte: reading=0, read slot advances, -> R_IDLE;
//    GOT_FULL_PACKET may rise the following cycle.
//  Commit and read-start in same cycle: PKT_COUNT net unchanged. Free-slot test uses registered counts
//   (conservative by at most one cycle). PKT_COUNT never exceeds SLOTS; packets leave in write order.
//  Counters saturate at all-ones; no wrap.
// TESTING
//  1. 3 back-to-back 188-byte packets (0x47, seq bytes) -> PKT_COUNT=3, GOT_FULL_PACKET=1; request ->
//     byte0=0x47 with DOUT_SYNC at T+2, 188 contiguous bytes matching input, PKT_COUNT=2.
//  2. SLOTS=4, 6 packets, no reads -> PKT_COUNT=4, DROP_COUNT=2; 4 reads return packets 1-4 in order.
//  3. P_SYNC+0x47 at byte 100 of a packet -> SHORT_COUNT=1, PKT_COUNT=1 after new packet, contents = new.
//  4. CHECK_SYNC=1, P_SYNC with DATA=0x48 in W_HUNT -> no write, counts unchanged; CHECK_SYNC=0 -> accepted.
//  5. D_VALID high 1 cycle in 3 while a read streams; last write byte coincides with read start ->
//     PKT_COUNT unchanged that cycle, all data intact.
//  6. RST=1 mid-read and mid-write -> next cycle all outputs 0, counts 0; next full packet stored normally.

Source files
------------

// File: rtl/ts_packet_ring_buffer.sv
// ----------------------------------------------------------------------------
// ts_packet_ring_buffer
//
// Captures a byte-wide transport stream into a ring of SLOTS packet slots.
// Packets are aligned on P_SYNC. Complete packets are handed out one at a
// time on request. A new packet is dropped when no slot is free. A packet is
// discarded as short when a fresh sync arrives before it is complete.
// Occupancy, drop and short counts are reported.
//
// Ports
//   SYS_CLK            : single clock
//   RST                : synchronous reset, active high
//   DATA / D_VALID     : input byte and its qualifier
//   P_SYNC             : first byte of a packet (qualified by D_VALID)
//   GIVE_ME_ONE_PACKET : read request, honoured while GOT_FULL_PACKET is high
//   GOT_FULL_PACKET    : a committed packet is available and the reader is idle
//   DATA_OUT           : output byte, zero when DOUT_VALID is low
//   DOUT_VALID         : DATA_OUT carries packet data
//   DOUT_SYNC          : high with the first byte of an output packet
//   PKT_COUNT          : committed, unread packets
//   DROP_COUNT         : packets lost for lack of a free slot (saturating)
//   SHORT_COUNT        : packets aborted by an early sync (saturating)
// ----------------------------------------------------------------------------
module ts_packet_ring_buffer #(
    parameter int DATA_W     = 8,
    parameter int PKT_LEN    = 188,
    parameter int SLOTS      = 4,
    parameter int CHECK_SYNC = 1,
    parameter int CNT_W      = 16
) (
    input  logic                       SYS_CLK,
    input  logic                       RST,
    input  logic [DATA_W-1:0]          DATA,
    input  logic                       D_VALID,
    input  logic                       P_SYNC,
    input  logic                       GIVE_ME_ONE_PACKET,
    output logic                       GOT_FULL_PACKET,
    output logic [DATA_W-1:0]          DATA_OUT,
    output logic                       DOUT_VALID,
    output logic                       DOUT_SYNC,
    output logic [$clog2(SLOTS):0]     PKT_COUNT,
    output logic [CNT_W-1:0]           DROP_COUNT,
    output logic [CNT_W-1:0]           SHORT_COUNT
);

    localparam int DEPTH = SLOTS * PKT_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int SW    = $clog2(SLOTS);
    localparam int PC_W  = $clog2(SLOTS) + 1;
    localparam int BW    = 8;

    localparam logic [AW-1:0]     PKT_LEN_A = AW'(PKT_LEN);
    localparam logic [AW-1:0]     ADDR_ZERO = {AW{1'b0}};
    localparam logic [BW-1:0]     LAST_OFS  = BW'(PKT_LEN - 1);
    localparam logic [BW-1:0]     PKT_LEN_B = BW'(PKT_LEN);
    localparam logic [BW-1:0]     CNT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0]     CNT_ONE   = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]     LAST_SLOT = SW'(SLOTS - 1);
    localparam logic [SW-1:0]     SLOT_ZERO = {SW{1'b0}};
    localparam logic [SW-1:0]     SLOT_ONE  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]   SLOTS_PC  = PC_W'(SLOTS);
    localparam logic [PC_W-1:0]   PC_ZERO   = {PC_W{1'b0}};
    localparam logic [PC_W-1:0]   PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  STAT_ZERO = {CNT_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(8'h47);

    localparam logic [0:0] W_HUNT = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_READ = 1'b1;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next slot index around the ring.
    function automatic logic [SW-1:0] next_slot(input logic [SW-1:0] s);
        if (s == LAST_SLOT) begin
            return SLOT_ZERO;
        end else begin
            return s + SLOT_ONE;
        end
    endfunction

    // Base address of the slot after s; wraps with the slot index so the
    // ring works for any PKT_LEN, not only powers of two.
    function automatic logic [AW-1:0] next_base(input logic [SW-1:0] s,
                                                input logic [AW-1:0] base);
        if (s == LAST_SLOT) begin
            return ADDR_ZERO;
        end else begin
            return base + PKT_LEN_A;
        end
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        w_state_q, w_state_d;
    logic [BW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [SW-1:0]     wr_slot_q, wr_slot_d;
    logic [AW-1:0]     wr_base_q, wr_base_d;

    logic [0:0]        r_state_q, r_state_d;
    logic [BW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [SW-1:0]     rd_slot_q, rd_slot_d;
    logic [AW-1:0]     rd_base_q, rd_base_d;

    logic [PC_W-1:0]   pkt_count_q, pkt_count_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  short_q, short_d;
    logic              got_full_q, got_full_d;

    logic [DATA_W-1:0] dout_data_q;
    logic              dout_valid_q, dout_valid_d;
    logic              dout_sync_q, dout_sync_d;

    logic              sync_ok_s;
    logic              reading_s;
    logic              slot_free_s;
    logic              accept_s;
    logic              commit_s;
    logic              mem_we_s;
    logic [AW-1:0]     mem_waddr_s;
    logic [AW-1:0]     rd_addr_s;

    assign sync_ok_s = D_VALID & P_SYNC & ((CHECK_SYNC == 0) || (DATA == SYNC_BYTE));
    assign reading_s = (r_state_q == R_READ);
    // Registered counts only: may refuse a packet one cycle longer than needed.
    assign slot_free_s = ((pkt_count_q + {{(PC_W-1){1'b0}}, reading_s}) < SLOTS_PC);
    assign accept_s  = (r_state_q == R_IDLE) & got_full_q & GIVE_ME_ONE_PACKET;
    assign rd_addr_s = rd_base_q + AW'(rd_cnt_q);

    // Write FSM next state: slot capture, short restart, drop and commit.
    always_comb begin
        w_state_d   = w_state_q;
        wr_cnt_d    = wr_cnt_q;
        wr_slot_d   = wr_slot_q;
        wr_base_d   = wr_base_q;
        drop_d      = drop_q;
        short_d     = short_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_base_q + AW'(wr_cnt_q);
        commit_s    = 1'b0;
        case (w_state_q)
            W_HUNT: begin
                if (sync_ok_s) begin
                    if (slot_free_s) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = wr_base_q;
                        wr_cnt_d    = CNT_ONE;
                        w_state_d   = W_FILL;
                    end else begin
                        drop_d = sat_inc(drop_q);
                    end
                end else begin
                    w_state_d = W_HUNT;
                end
            end
            W_FILL: begin
                if (D_VALID) begin
                    mem_we_s = 1'b1;
                    if (sync_ok_s) begin
                        // Early sync: abandon the partial packet, reuse the slot.
                        short_d     = sat_inc(short_q);
                        mem_waddr_s = wr_base_q;
                        wr_cnt_d    = CNT_ONE;
                    end else if (wr_cnt_q == LAST_OFS) begin
                        commit_s  = 1'b1;
                        wr_cnt_d  = CNT_ZERO;
                        wr_slot_d = next_slot(wr_slot_q);
                        wr_base_d = next_base(wr_slot_q, wr_base_q);
                        w_state_d = W_HUNT;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                    end
                end else begin
                    w_state_d = W_FILL;
                end
            end
            default: begin
                w_state_d = W_HUNT;
                wr_cnt_d  = CNT_ZERO;
            end
        endcase
    end

    // Read FSM next state: one extra cycle after the last byte before idle.
    always_comb begin
        r_state_d    = r_state_q;
        rd_cnt_d     = rd_cnt_q;
        rd_slot_d    = rd_slot_q;
        rd_base_d    = rd_base_q;
        dout_valid_d = 1'b0;
        dout_sync_d  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (accept_s) begin
                    r_state_d = R_READ;
                    rd_cnt_d  = CNT_ZERO;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_READ: begin
                if (rd_cnt_q == PKT_LEN_B) begin
                    r_state_d = R_IDLE;
                    rd_cnt_d  = CNT_ZERO;
                    rd_slot_d = next_slot(rd_slot_q);
                    rd_base_d = next_base(rd_slot_q, rd_base_q);
                end else begin
                    dout_valid_d = 1'b1;
                    dout_sync_d  = (rd_cnt_q == CNT_ZERO);
                    rd_cnt_d     = rd_cnt_q + CNT_ONE;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rd_cnt_d  = CNT_ZERO;
            end
        endcase
    end

    // Packet count and availability flag; commit and read-start cancel out.
    always_comb begin
        case ({commit_s, accept_s})
            2'b10:   pkt_count_d = pkt_count_q + PC_ONE;
            2'b01:   pkt_count_d = pkt_count_q - PC_ONE;
            default: pkt_count_d = pkt_count_q;
        endcase
        got_full_d = (r_state_q == R_IDLE) && !accept_s && (pkt_count_q != PC_ZERO);
    end

    // Writer state registers.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            w_state_q <= W_HUNT;
            wr_cnt_q  <= CNT_ZERO;
            wr_slot_q <= SLOT_ZERO;
            wr_base_q <= ADDR_ZERO;
        end else begin
            w_state_q <= w_state_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_slot_q <= wr_slot_d;
            wr_base_q <= wr_base_d;
        end
    end

    // Reader state registers.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_state_q <= R_IDLE;
            rd_cnt_q  <= CNT_ZERO;
            rd_slot_q <= SLOT_ZERO;
            rd_base_q <= ADDR_ZERO;
        end else begin
            r_state_q <= r_state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_slot_q <= rd_slot_d;
            rd_base_q <= rd_base_d;
        end
    end

    // Occupancy, statistics and availability registers.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            pkt_count_q <= PC_ZERO;
            drop_q      <= STAT_ZERO;
            short_q     <= STAT_ZERO;
            got_full_q  <= 1'b0;
        end else begin
            pkt_count_q <= pkt_count_d;
            drop_q      <= drop_d;
            short_q     <= short_d;
            got_full_q  <= got_full_d;
        end
    end

    // Packet RAM write port; contents survive reset.
    always_ff @(posedge SYS_CLK) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= DATA;
        end
    end

    // Registered RAM read port; output forced to zero when not streaming.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            dout_data_q  <= DATA_ZERO;
            dout_valid_q <= 1'b0;
            dout_sync_q  <= 1'b0;
        end else begin
            dout_valid_q <= dout_valid_d;
            dout_sync_q  <= dout_sync_d;
            if (dout_valid_d) begin
                dout_data_q <= mem[rd_addr_s];
            end else begin
                dout_data_q <= DATA_ZERO;
            end
        end
    end

    assign GOT_FULL_PACKET = got_full_q;
    assign DATA_OUT        = dout_data_q;
    assign DOUT_VALID      = dout_valid_q;
    assign DOUT_SYNC       = dout_sync_q;
    assign PKT_COUNT       = pkt_count_q;
    assign DROP_COUNT      = drop_q;
    assign SHORT_COUNT     = short_q;

endmodule

// File: tb/tb_ts_packet_ring_buffer.sv
// Directed bench for ts_packet_ring_buffer. Expected bytes are queued when a
// packet that must survive is driven and compared as the DUT streams it out.
module tb_ts_packet_ring_buffer;

    localparam int PKT_LEN = 188;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        d_valid;
    logic        p_sync;
    logic        give;
    logic        got_full;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_sync;
    logic [2:0]  pkt_count;
    logic [15:0] drop_count;
    logic [15:0] short_count;

    logic        rst2;
    logic        d2_got_full;
    logic [7:0]  d2_dout;
    logic        d2_dout_valid;
    logic        d2_dout_sync;
    logic [2:0]  d2_pkt_count;
    logic [15:0] d2_drop_count;
    logic [15:0] d2_short_count;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    ts_packet_ring_buffer #(.DATA_W(8), .PKT_LEN(PKT_LEN), .SLOTS(4), .CHECK_SYNC(1), .CNT_W(16)) dut (
        .SYS_CLK(clk), .RST(rst), .DATA(data), .D_VALID(d_valid), .P_SYNC(p_sync),
        .GIVE_ME_ONE_PACKET(give), .GOT_FULL_PACKET(got_full), .DATA_OUT(dout),
        .DOUT_VALID(dout_valid), .DOUT_SYNC(dout_sync), .PKT_COUNT(pkt_count),
        .DROP_COUNT(drop_count), .SHORT_COUNT(short_count)
    );

    ts_packet_ring_buffer #(.DATA_W(8), .PKT_LEN(PKT_LEN), .SLOTS(4), .CHECK_SYNC(0), .CNT_W(16)) dut_nochk (
        .SYS_CLK(clk), .RST(rst2), .DATA(data), .D_VALID(d_valid), .P_SYNC(p_sync),
        .GIVE_ME_ONE_PACKET(1'b0), .GOT_FULL_PACKET(d2_got_full), .DATA_OUT(d2_dout),
        .DOUT_VALID(d2_dout_valid), .DOUT_SYNC(d2_dout_sync), .PKT_COUNT(d2_pkt_count),
        .DROP_COUNT(d2_drop_count), .SHORT_COUNT(d2_short_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int seed, input int i);
        if (i == 0) return 8'h47;
        return 8'((seed * 37 + i * 3 + 1) & 255);
    endfunction

    // Drive len bytes of packet 'seed'; bad_at >= 0 puts P_SYNC with 0x48 there.
    task automatic send_pkt(input int seed, input int len, input bit push, input int bad_at);
        for (int i = 0; i < len; i++) begin
            data    = (i == bad_at) ? 8'h48 : pat(seed, i);
            p_sync  = (i == 0) || (i == bad_at);
            d_valid = 1'b1;
            if (push) sb.push_back({(i == 0), data});
            tick();
        end
        d_valid = 1'b0;
        p_sync  = 1'b0;
    endtask

    // Request one packet and check handshake timing and contiguous length.
    task automatic read_pkt(input int exp_cnt);
        int n;
        n = 0;
        while (!got_full && n < 2000) begin
            tick();
            n++;
        end
        chk("got_full_before_req", 32'(got_full), 32'd1);
        chk("pkt_count_before_req", 32'(pkt_count), 32'(exp_cnt));
        give = 1'b1;
        tick();
        give = 1'b0;
        chk("got_full_after_req", 32'(got_full), 32'd0);
        chk("pkt_count_after_req", 32'(pkt_count), 32'(exp_cnt - 1));
        chk("dout_valid_t1", 32'(dout_valid), 32'd0);
        tick();
        chk("dout_valid_t2", 32'(dout_valid), 32'd1);
        chk("dout_sync_t2", 32'(dout_sync), 32'd1);
        chk("dout_byte0", 32'(dout), 32'h47);
        n = 1;
        tick();
        while (dout_valid && n < PKT_LEN + 10) begin
            n++;
            tick();
        end
        chk("packet_length", 32'(n), 32'(PKT_LEN));
    endtask

    // Scoreboard: every streamed byte must match the oldest queued byte.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (dout_valid) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
            chk("dout_stream", 32'({dout_sync, dout}), 32'(exp));
        end else begin
            chk("idle_data_zero", 32'(dout), 32'd0);
        end
    end

    initial begin
        int n;
        rst = 1'b1; rst2 = 1'b1; data = 8'h00; d_valid = 1'b0; p_sync = 1'b0; give = 1'b0;
        tick(); tick(); tick();
        chk("rst_got_full", 32'(got_full), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout_sync", 32'(dout_sync), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_short", 32'(short_count), 32'd0);
        rst = 1'b0;
        tick();

        // 1: three back-to-back packets, then read all in order
        for (int k = 1; k <= 3; k++) send_pkt(k, PKT_LEN, 1'b1, -1);
        tick(); tick();
        chk("t1_pkt_count", 32'(pkt_count), 32'd3);
        chk("t1_got_full", 32'(got_full), 32'd1);
        read_pkt(3); read_pkt(2); read_pkt(1);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // 2: six packets into four slots, the last two are dropped
        for (int k = 10; k < 16; k++) send_pkt(k, PKT_LEN, (k < 14), -1);
        tick(); tick();
        chk("t2_pkt_count", 32'(pkt_count), 32'd4);
        chk("t2_drop", 32'(drop_count), 32'd2);
        read_pkt(4); read_pkt(3); read_pkt(2); read_pkt(1);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 3: sync at byte 100 aborts the packet, new packet survives
        send_pkt(20, 100, 1'b0, -1);
        send_pkt(21, PKT_LEN, 1'b1, -1);
        tick(); tick();
        chk("t3_short", 32'(short_count), 32'd1);
        chk("t3_pkt_count", 32'(pkt_count), 32'd1);
        read_pkt(1);

        // 4: P_SYNC with 0x48 in hunt: ignored when checked, accepted otherwise
        rst2 = 1'b0;
        tick();
        for (int i = 0; i < PKT_LEN; i++) begin
            data = (i == 0) ? 8'h48 : pat(9, i);
            p_sync = (i == 0); d_valid = 1'b1;
            tick();
        end
        d_valid = 1'b0; p_sync = 1'b0;
        tick(); tick();
        chk("t4_pkt_count", 32'(pkt_count), 32'd0);
        chk("t4_got_full", 32'(got_full), 32'd0);
        chk("t4_drop", 32'(drop_count), 32'd2);
        chk("t4_short", 32'(short_count), 32'd1);
        chk("t4_nochk_pkt_count", 32'(d2_pkt_count), 32'd1);
        // inside a packet an unqualified sync is plain data
        send_pkt(30, PKT_LEN, 1'b1, 50);
        tick(); tick();
        chk("t4_data_short", 32'(short_count), 32'd1);
        read_pkt(1);
        rst2 = 1'b1;

        // 5: slow writer during a read; last write byte meets the next read start
        send_pkt(40, PKT_LEN, 1'b1, -1);
        send_pkt(41, PKT_LEN, 1'b1, -1);
        n = 0;
        while (!got_full && n < 100) begin tick(); n++; end
        chk("t5_got_full_start", 32'(got_full), 32'd1);
        for (int cyc = 0; cyc < 3 * PKT_LEN - 2; cyc++) begin
            d_valid = (cyc % 3 == 0);
            data    = pat(42, cyc / 3);
            p_sync  = (cyc == 0);
            if (d_valid) sb.push_back({(cyc == 0), data});
            give = (cyc == 0) || (cyc == 3 * PKT_LEN - 3);
            if (cyc == 3 * PKT_LEN - 3) begin
                chk("t5_got_full_collide", 32'(got_full), 32'd1);
                chk("t5_pkt_count_before", 32'(pkt_count), 32'd1);
            end
            tick();
        end
        d_valid = 1'b0; give = 1'b0; p_sync = 1'b0;
        chk("t5_pkt_count_after", 32'(pkt_count), 32'd1);
        chk("t5_got_full_after", 32'(got_full), 32'd0);
        tick();
        chk("t5_pkt_count_hold", 32'(pkt_count), 32'd1);
        read_pkt(1);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);

        // 6: reset in the middle of a read and a write
        send_pkt(50, PKT_LEN, 1'b1, -1);
        n = 0;
        while (!got_full && n < 100) begin tick(); n++; end
        chk("t6_got_full", 32'(got_full), 32'd1);
        for (int i = 0; i < 60; i++) begin
            data = pat(51, i); p_sync = (i == 0); d_valid = 1'b1; give = (i == 0);
            tick();
        end
        chk("t6_mid_read_valid", 32'(dout_valid), 32'd1);
        rst = 1'b1; d_valid = 1'b0; p_sync = 1'b0; give = 1'b0;
        tick();
        chk("t6_got_full", 32'(got_full), 32'd0);
        chk("t6_dout", 32'(dout), 32'd0);
        chk("t6_dout_valid", 32'(dout_valid), 32'd0);
        chk("t6_dout_sync", 32'(dout_sync), 32'd0);
        chk("t6_pkt_count", 32'(pkt_count), 32'd0);
        chk("t6_drop", 32'(drop_count), 32'd0);
        chk("t6_short", 32'(short_count), 32'd0);
        sb.delete();
        rst = 1'b0;
        tick();
        send_pkt(52, PKT_LEN, 1'b1, -1);
        tick(); tick();
        chk("t6_pkt_count_new", 32'(pkt_count), 32'd1);
        read_pkt(1);
        tick(); tick();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_pkt_count", 32'(pkt_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
